// File: rtl/pid_axis_scheduler.sv
// rtl/pid_axis_scheduler.sv - time-shares one PID engine across X/Y/Z axes
// Captures wrapped per-axis errors, keeps per-axis context, publishes outputs atomically.
module pid_axis_scheduler #(
  parameter int WIDTH     = 9,
  parameter int ACC_WIDTH = 16,
  parameter int WRAP      = 360
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 clear_ctx,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic [WIDTH-1:0]     mpu_x,
  input  logic [WIDTH-1:0]     mpu_y,
  input  logic [WIDTH-1:0]     mpu_z,
  input  logic [WIDTH-1:0]     set_x,
  input  logic [WIDTH-1:0]     set_y,
  input  logic [WIDTH-1:0]     set_z,
  output logic                 eng_req,
  output logic [1:0]           eng_axis,
  output logic [WIDTH:0]       eng_error,
  output logic [WIDTH:0]       eng_prev_error,
  output logic [ACC_WIDTH-1:0] eng_integral,
  input  logic                 eng_ack,
  input  logic [WIDTH:0]       eng_out,
  input  logic [ACC_WIDTH-1:0] eng_integral_next,
  output logic [WIDTH:0]       out_x,
  output logic [WIDTH:0]       out_y,
  output logic [WIDTH:0]       out_z,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {IDLE, READY, ISSUE, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           axis_q;
  logic [WIDTH:0]       err_q    [3];
  logic [WIDTH:0]       prev_q   [3];
  logic [ACC_WIDTH-1:0] integ_q  [3];
  logic [WIDTH:0]       shadow_q [2];
  logic                 accept;
  logic                 ctx_clear;
  logic                 ack_take;

  // Shortest-path angular error; exactly +/-WRAP/2 is left as computed.
  function automatic logic [WIDTH:0] wrap_err(input logic [WIDTH-1:0] set_a,
                                              input logic [WIDTH-1:0] meas_a);
    int d;
    d = int'(set_a) - int'(meas_a);
    if (WRAP != 0) begin
      if (d > WRAP / 2)
        d = d - WRAP;
      else if (d < -(WRAP / 2))
        d = d + WRAP;
    end
    return d[WIDTH:0];
  endfunction

  assign accept    = (state_q == READY) && sample_valid;
  assign ctx_clear = clear_ctx && ((state_q == IDLE) || (state_q == READY));
  assign ack_take  = (state_q == ISSUE) && eng_ack;

  assign sample_ready   = (state_q == READY);
  assign eng_req        = (state_q == ISSUE);
  assign out_valid      = (state_q == DONE);
  assign busy           = (state_q == ISSUE) || (state_q == DONE);
  assign eng_axis       = axis_q;
  assign eng_error      = err_q[axis_q];
  assign eng_prev_error = prev_q[axis_q];
  assign eng_integral   = integ_q[axis_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READY;
      READY: begin
        if (sample_valid)
          state_d = ISSUE;
        else if (!start)
          state_d = IDLE;
      end
      ISSUE:   if (eng_ack && (axis_q == 2'd2)) state_d = DONE;
      DONE:    state_d = start ? READY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      axis_q  <= '0;
      out_x   <= '0;
      out_y   <= '0;
      out_z   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        err_q[i]   <= '0;
        prev_q[i]  <= '0;
        integ_q[i] <= '0;
      end
      for (int i = 0; i < 2; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (ctx_clear) begin
        overrun <= 1'b0;
        for (int i = 0; i < 3; i++) begin
          prev_q[i]  <= '0;
          integ_q[i] <= '0;
        end
      end
      // A dropped sample outranks a same-cycle clear: the loss must stay visible.
      if (sample_valid && (state_q != READY))
        overrun <= 1'b1;
      if (accept) begin
        err_q[0] <= wrap_err(set_x, mpu_x);
        err_q[1] <= wrap_err(set_y, mpu_y);
        err_q[2] <= wrap_err(set_z, mpu_z);
        axis_q   <= 2'd0;
      end
      if (ack_take) begin
        integ_q[axis_q] <= eng_integral_next;
        prev_q[axis_q]  <= err_q[axis_q];
        // Outputs load together on entry to DONE so they coincide with out_valid.
        if (axis_q == 2'd2) begin
          out_x <= shadow_q[0];
          out_y <= shadow_q[1];
          out_z <= eng_out;
        end else begin
          shadow_q[axis_q[0]] <= eng_out;
          axis_q              <= axis_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_axis_scheduler.sv
// tb/tb_pid_axis_scheduler.sv - self-checking bench for pid_axis_scheduler
module tb_pid_axis_scheduler;

  localparam int WRAP = 360;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_ctx = 1'b0;
  logic        sample_valid = 1'b0;
  logic [8:0]  mpu_x = '0, mpu_y = '0, mpu_z = '0;
  logic [8:0]  set_x = '0, set_y = '0, set_z = '0;
  logic        eng_ack = 1'b0;
  logic signed [9:0]  eng_out = '0;
  logic signed [15:0] eng_integral_next = '0;

  logic        sample_ready, eng_req, out_valid, busy, overrun;
  logic [1:0]  eng_axis;
  logic [9:0]  eng_error, eng_prev_error, out_x, out_y, out_z;
  logic [15:0] eng_integral;

  pid_axis_scheduler #(.WIDTH(9), .ACC_WIDTH(16), .WRAP(WRAP)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .clear_ctx(clear_ctx),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .mpu_x(mpu_x), .mpu_y(mpu_y), .mpu_z(mpu_z),
    .set_x(set_x), .set_y(set_y), .set_z(set_z),
    .eng_req(eng_req), .eng_axis(eng_axis), .eng_error(eng_error),
    .eng_prev_error(eng_prev_error), .eng_integral(eng_integral),
    .eng_ack(eng_ack), .eng_out(eng_out), .eng_integral_next(eng_integral_next),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0, cyc = 0, t_acc = 0, lat = 0;
  // Model phases: 0 idle, 1 waiting for a sample, 2 engine busy on m_axis, 3 publish cycle
  int m_st, m_axis;
  int m_err[3], m_prev[3], m_integ[3], m_shadow[3], m_out[3];
  int m_ovr;
  int waits[3];
  int wctr;
  bit rand_eng = 1'b0;

  function automatic int wrap_err(int s, int m);
    int d;
    d = s - m;
    if (d > WRAP / 2) d -= WRAP;
    else if (d < -(WRAP / 2)) d += WRAP;
    return d;
  endfunction

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_axis = 0; m_ovr = 0; wctr = 0;
    for (int i = 0; i < 3; i++) begin
      m_err[i] = 0; m_prev[i] = 0; m_integ[i] = 0; m_shadow[i] = 0; m_out[i] = 0;
    end
  endtask

  // One cycle: engine response, compare against model, advance model, move to next negedge.
  task automatic step();
    if (rand_eng) begin
      eng_ack = 1'($urandom_range(0, 1));
      eng_out = 10'($urandom);
      eng_integral_next = 16'($urandom);
    end else if (m_st == 2) begin
      if (wctr >= waits[m_axis]) begin
        eng_ack = 1'b1; wctr = 0;
      end else begin
        eng_ack = 1'b0; wctr++;
      end
      eng_out = 10'(m_err[m_axis]);
      eng_integral_next = 16'(m_integ[m_axis] + m_err[m_axis]);
    end else begin
      eng_ack = 1'b0;
    end

    check("sample_ready", 32'(sample_ready), int'(m_st == 1));
    check("eng_req", 32'(eng_req), int'(m_st == 2));
    check("out_valid", 32'(out_valid), int'(m_st == 3));
    check("busy", 32'(busy), int'(m_st >= 2));
    check("overrun", 32'(overrun), m_ovr);
    check("out_x", 32'($signed(out_x)), m_out[0]);
    check("out_y", 32'($signed(out_y)), m_out[1]);
    check("out_z", 32'($signed(out_z)), m_out[2]);
    if (m_st == 2) begin
      check("eng_axis", 32'(eng_axis), m_axis);
      check("eng_error", 32'($signed(eng_error)), m_err[m_axis]);
      check("eng_prev_error", 32'($signed(eng_prev_error)), m_prev[m_axis]);
      check("eng_integral", 32'($signed(eng_integral)), m_integ[m_axis]);
    end

    if (sample_valid && m_st != 1) m_ovr = 1;
    else if (clear_ctx && m_st <= 1) m_ovr = 0;
    if (clear_ctx && m_st <= 1)
      for (int i = 0; i < 3; i++) begin m_prev[i] = 0; m_integ[i] = 0; end
    case (m_st)
      0: if (start) m_st = 1;
      1: begin
        if (sample_valid) begin
          m_err[0] = wrap_err(int'(set_x), int'(mpu_x));
          m_err[1] = wrap_err(int'(set_y), int'(mpu_y));
          m_err[2] = wrap_err(int'(set_z), int'(mpu_z));
          m_axis = 0; m_st = 2;
        end else if (!start) m_st = 0;
      end
      2: if (eng_ack) begin
        m_shadow[m_axis] = int'(eng_out);
        m_integ[m_axis]  = int'(eng_integral_next);
        m_prev[m_axis]   = m_err[m_axis];
        if (m_axis == 2) begin
          for (int i = 0; i < 3; i++) m_out[i] = m_shadow[i];
          m_st = 3;
        end else m_axis++;
      end
      default: m_st = start ? 1 : 0;
    endcase
    @(negedge clock);
    cyc++;
  endtask

  task automatic run_frame(input int sx, input int mx, input int sy, input int my,
                           input int sz, input int mz);
    set_x = 9'(sx); mpu_x = 9'(mx); set_y = 9'(sy); mpu_y = 9'(my);
    set_z = 9'(sz); mpu_z = 9'(mz);
    sample_valid = 1'b1;
    t_acc = cyc;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(output int latency);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin step(); k++; end
    if (k == 40) check("out_valid_timeout", 32'(out_valid), 1);
    latency = cyc - t_acc;
    step();
  endtask

  initial begin
    model_reset();
    waits[0] = 0; waits[1] = 0; waits[2] = 0;
    repeat (2) @(negedge clock);
    check("rst_out_x", 32'(out_x), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_eng_req", 32'(eng_req), 0);
    check("rst_sample_ready", 32'(sample_ready), 0);
    reset_n = 1'b1; start = 1'b1;
    step();
    check("ready_after_start", 32'(sample_ready), 1);

    run_frame(90, 80, 90, 80, 90, 80);
    check("basic_err", 32'($signed(eng_error)), 10);
    check("basic_prev", 32'($signed(eng_prev_error)), 0);
    wait_valid(lat);
    check("basic_latency", lat, 4);
    check("basic_out_x", 32'($signed(out_x)), 10);
    run_frame(90, 80, 90, 80, 90, 80);
    check("second_prev", 32'($signed(eng_prev_error)), 10);
    check("second_integral", 32'($signed(eng_integral)), 10);
    wait_valid(lat);

    run_frame(10, 350, 350, 10, 180, 0);
    check("wrap_pos", 32'($signed(eng_error)), 20);
    step();
    check("wrap_neg", 32'($signed(eng_error)), -20);
    step();
    check("wrap_half", 32'($signed(eng_error)), 180);
    wait_valid(lat);

    waits[1] = 5;
    run_frame(100, 50, 30, 200, 0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_axis", 32'(eng_axis), 1);
      check("stall_err", 32'($signed(eng_error)), -170);
      step();
    end
    wait_valid(lat);
    check("stall_latency", lat, 9);
    check("stall_out_y", 32'($signed(out_y)), -170);
    waits[1] = 0;

    run_frame(40, 10, 40, 10, 40, 10);
    set_x = 9'd0; mpu_x = 9'd100; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check("overrun_set", 32'(overrun), 1);
    wait_valid(lat);
    check("overrun_out_x", 32'($signed(out_x)), 30);
    clear_ctx = 1'b1;
    step();
    clear_ctx = 1'b0;
    check("overrun_cleared", 32'(overrun), 0);
    run_frame(40, 10, 40, 10, 40, 10);
    check("cleared_integral", 32'($signed(eng_integral)), 0);
    wait_valid(lat);

    run_frame(70, 20, 70, 20, 70, 20);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_req", 32'(eng_req), 0);
    check("async_rst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    step();
    run_frame(70, 20, 70, 20, 70, 20);
    check("post_rst_prev", 32'($signed(eng_prev_error)), 0);
    wait_valid(lat);

    rand_eng = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      sample_valid = ($urandom_range(0, 2) == 0);
      start = sample_valid ? 1'b1 : ($urandom_range(0, 9) != 0);
      clear_ctx = ($urandom_range(0, 24) == 0) && (!sample_valid || m_st == 1);
      mpu_x = 9'($urandom); mpu_y = 9'($urandom); mpu_z = 9'($urandom);
      set_x = 9'($urandom); set_y = 9'($urandom); set_z = 9'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
